sprite_motion_ctrl: RTL



---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_motion_ctrl_if.sv | 24 ++
 rtl/sprite_motion_ctrl_btn_sync_edge.sv | 35 +++
 rtl/sprite_motion_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller and the pixel renderer.
// Holds the direction encoding, controller state type and the colour palette.
package sprite_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_NONE  = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_DOWN  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  // RGB565 palette the renderer uses to draw the scene
  localparam logic [15:0] COLOR_BACKGROUND = 16'h0000;
  localparam logic [15:0] COLOR_SPRITE     = 16'h07E0;
  localparam logic [15:0] COLOR_BLOCKED    = 16'hFFE0;
  localparam logic [15:0] COLOR_OBSTACLE   = 16'hF800;

  // Inclusive 1-D overlap of [lo,hi] against [lim_lo,lim_hi]
  function automatic logic span_overlap(input logic [7:0] lo, input logic [7:0] hi,
                                        input logic [7:0] lim_lo, input logic [7:0] lim_hi);
    return (lo <= lim_hi) && (hi >= lim_lo);
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Button input and motion-status bundle between the button/renderer side and the controller.
// The controller attaches through the slave modport.
interface sprite_motion_ctrl_if;
  import sprite_pkg::*;

  logic [4:0] btn;
  logic [6:0] ptr_x;
  logic [5:0] ptr_y;
  dir_t       dir;
  logic       moving;
  logic       blocked;
  logic       obs_hit;

  modport master (
    output btn,
    input  ptr_x, ptr_y, dir, moving, blocked, obs_hit
  );

  modport slave (
    input  btn,
    output ptr_x, ptr_y, dir, moving, blocked, obs_hit
  );

endinterface

// File: rtl/sprite_motion_ctrl_btn_sync_edge.sv
// Per-bit 2-FF synchroniser followed by a rising-edge detector for the raw push-buttons.
// press is combinational from the synchronised bit and its delayed copy.
module btn_sync_edge #(
  parameter int WIDTH = 5
) (
  input  logic             clksig,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clksig or posedge rst) begin
        if (rst) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
          prev_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= btn[gi];
          sync_reg[gi] <= meta_reg[gi];
          prev_reg[gi] <= sync_reg[gi];
        end
      end

      assign press[gi] = sync_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Motion policy for the 7x7 sprite: button decode, paced stepping, edge/obstacle refusal.
// Optional SPRITE_WRAP_EN: steps past a screen edge wrap around instead of blocking.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int X_SIZE   = 96,
  parameter int Y_SIZE   = 64,
  parameter int BOX_SIZE = 7,
  parameter int START_X  = 4,
  parameter int START_Y  = 4,
  parameter int OBS_X0   = 35,
  parameter int OBS_X1   = 60,
  parameter int OBS_Y0   = 20,
  parameter int OBS_Y1   = 45,
  parameter int STEP_DIV = 100000
) (
  input  logic                 clksig,
  input  logic                 rst,
  sprite_motion_ctrl_if.slave  bus
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [7:0] BOX_M1 = 8'(BOX_SIZE - 1);
  localparam logic [7:0] BOX8   = 8'(BOX_SIZE);
  localparam logic [7:0] X_LAST = 8'(X_SIZE - 1);
  localparam logic [7:0] Y_LAST = 8'(Y_SIZE - 1);
  localparam logic [7:0] X_WRAP = 8'(X_SIZE - BOX_SIZE);
  localparam logic [7:0] Y_WRAP = 8'(Y_SIZE - BOX_SIZE);
  localparam logic [7:0] OX0    = 8'(OBS_X0);
  localparam logic [7:0] OX1    = 8'(OBS_X1);
  localparam logic [7:0] OY0    = 8'(OBS_Y0);
  localparam logic [7:0] OY1    = 8'(OBS_Y1);
  localparam logic [7:0] OX1_P1 = 8'(OBS_X1 + 1);
  localparam logic [7:0] OY1_P1 = 8'(OBS_Y1 + 1);

  state_t           state_reg, state_next;
  dir_t             dir_reg, dir_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [6:0]       ptr_x_reg, ptr_x_next;
  logic [5:0]       ptr_y_reg, ptr_y_next;
  logic             blocked_reg, blocked_next;
  logic             obs_hit_reg, obs_hit_next;

  logic [4:0] press;
  logic       cmd_center;
  dir_t       cmd_dir;
  logic       tick;

  logic [7:0] x_lo, x_hi, y_lo, y_hi;
  logic [7:0] cand_x, cand_y;
  logic       x_ov, y_ov;
  logic       at_edge, hit_obs;
  logic       step_ok, step_obs;

  btn_sync_edge #(.WIDTH(5)) u_sync (
    .clksig (clksig),
    .rst    (rst),
    .btn    (bus.btn),
    .press  (press)
  );

  // Centre overrides every direction; among directions up > down > left > right
  always_comb begin
    cmd_center = press[0];
    cmd_dir    = DIR_NONE;
    if (press[1])      cmd_dir = DIR_UP;
    else if (press[4]) cmd_dir = DIR_DOWN;
    else if (press[2]) cmd_dir = DIR_LEFT;
    else if (press[3]) cmd_dir = DIR_RIGHT;
  end

  assign tick = (div_reg == DIV_LAST);

  // Candidate next position and the two refusal causes for the latched direction
  always_comb begin
    x_lo    = {1'b0, ptr_x_reg};
    y_lo    = {2'b00, ptr_y_reg};
    x_hi    = x_lo + BOX_M1;
    y_hi    = y_lo + BOX_M1;
    x_ov    = span_overlap(x_lo, x_hi, OX0, OX1);
    y_ov    = span_overlap(y_lo, y_hi, OY0, OY1);
    at_edge = 1'b0;
    hit_obs = 1'b0;
    cand_x  = x_lo;
    cand_y  = y_lo;
    case (dir_reg)
      DIR_UP: begin
        at_edge = (y_lo == 8'd0);
        hit_obs = (y_lo == OY1_P1) && x_ov;
        cand_y  = at_edge ? Y_WRAP : y_lo - 8'd1;
      end
      DIR_DOWN: begin
        at_edge = (y_hi == Y_LAST);
        hit_obs = ((y_lo + BOX8) == OY0) && x_ov;
        cand_y  = at_edge ? 8'd0 : y_lo + 8'd1;
      end
      DIR_LEFT: begin
        at_edge = (x_lo == 8'd0);
        hit_obs = (x_lo == OX1_P1) && y_ov;
        cand_x  = at_edge ? X_WRAP : x_lo - 8'd1;
      end
      DIR_RIGHT: begin
        at_edge = (x_hi == X_LAST);
        hit_obs = ((x_lo + BOX8) == OX0) && y_ov;
        cand_x  = at_edge ? 8'd0 : x_lo + 8'd1;
      end
      default: ;
    endcase
  end

`ifdef SPRITE_WRAP_EN
  logic wrap_hit;

  // A wrapped sprite must not land on the obstacle; that refusal is reported as an obstacle hit
  assign wrap_hit = span_overlap(cand_x, cand_x + BOX_M1, OX0, OX1) &&
                    span_overlap(cand_y, cand_y + BOX_M1, OY0, OY1);
  assign step_ok  = !hit_obs && !(at_edge && wrap_hit);
  assign step_obs = 1'b1;
`else
  assign step_ok  = !hit_obs && !at_edge;
  assign step_obs = hit_obs;
`endif

  logic unused_bits;
  assign unused_bits = ^{cand_x[7], cand_y[7:6]};

  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    div_next     = div_reg;
    ptr_x_next   = ptr_x_reg;
    ptr_y_next   = ptr_y_reg;
    blocked_next = 1'b0;
    obs_hit_next = obs_hit_reg;
    case (state_reg)
      IDLE: begin
        dir_next = DIR_NONE;
        div_next = '0;
        if (!cmd_center && cmd_dir != DIR_NONE) begin
          state_next = MOVE;
          dir_next   = cmd_dir;
        end
      end
      MOVE: begin
        // Any press on a tick cycle wins and the tick is dropped
        if (cmd_center) begin
          state_next = IDLE;
          dir_next   = DIR_NONE;
          div_next   = '0;
        end else if (cmd_dir != DIR_NONE) begin
          dir_next = cmd_dir;
          div_next = '0;
        end else if (tick) begin
          div_next = '0;
          if (step_ok) begin
            ptr_x_next = cand_x[6:0];
            ptr_y_next = cand_y[5:0];
          end else begin
            state_next   = BLOCKED;
            blocked_next = 1'b1;
            obs_hit_next = step_obs;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      BLOCKED: begin
        if (cmd_center) begin
          state_next   = IDLE;
          dir_next     = DIR_NONE;
          obs_hit_next = 1'b0;
        end else if (cmd_dir != DIR_NONE) begin
          state_next   = MOVE;
          dir_next     = cmd_dir;
          div_next     = '0;
          obs_hit_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        dir_next   = DIR_NONE;
        div_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clksig or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      dir_reg     <= DIR_NONE;
      div_reg     <= '0;
      ptr_x_reg   <= 7'(START_X);
      ptr_y_reg   <= 6'(START_Y);
      blocked_reg <= 1'b0;
      obs_hit_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      div_reg     <= div_next;
      ptr_x_reg   <= ptr_x_next;
      ptr_y_reg   <= ptr_y_next;
      blocked_reg <= blocked_next;
      obs_hit_reg <= obs_hit_next;
    end
  end

  assign bus.ptr_x   = ptr_x_reg;
  assign bus.ptr_y   = ptr_y_reg;
  assign bus.dir     = dir_reg;
  assign bus.moving  = (state_reg == MOVE);
  assign bus.blocked = blocked_reg;
  assign bus.obs_hit = obs_hit_reg;

endmodule
